rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single SDRAM ROM read channel between up to NUM_PORTS requesters:
  - 68k program-ROM cache miss path;
  - Z80 sound ROM;
  - tile/sprite ROM fetchers.
- Round-robin arbitration with one outstanding SDRAM read at a time.
- Each requester uses the same level handshake as the cache's ROM port: hold req, receive a one-cycle valid.
- Sits between the requesters and the SDRAM controller port.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- AW, 23, word address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-port read request, level, held until valid.
- addr  in  NUM_PORTS*AW  per-port word address, port i at [i*AW +: AW].
- valid  out  NUM_PORTS  per-port one-cycle data-ready pulse.
- data  out  DW  read data, shared by all ports, qualified by valid[i].
- grant  out  3  index of the port currently owning SDRAM.
- busy  out  1  SDRAM transaction in flight.
- sdram_req  out  1  request to the SDRAM controller, level.
- sdram_addr  out  AW  address to the SDRAM controller.
- sdram_data  in  DW  SDRAM read data.
- sdram_valid  in  1  one-cycle SDRAM data-ready pulse.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - valid=0, data=0, grant=0, busy=0, sdram_req=0, sdram_addr=0.
  - state=IDLE, served=0, last=NUM_PORTS-1, so port 0 wins first.
- Eligibility:
  - eligible[i] = req[i] & ~served[i].
  - served[i] is set when valid[i] pulses.
  - served[i] is cleared on any cycle req[i]==0.
  - A requester that holds req after its valid, as the cache does, is not re-served until it drops req for at least one cycle.
- Round-robin pick:
  - Search from last+1 upward with wrap modulo NUM_PORTS.
  - The first eligible index wins.
  - last is updated to the winner at grant.
- State IDLE:
  - If any port is eligible: grant<=sel, sdram_addr<=addr[sel], sdram_req<=1, busy<=1, go to WAIT.
  - Latency: req sampled high at edge t gives sdram_req high after edge t.
- State WAIT:
  - sdram_req and sdram_addr are held stable.
  - addr changes from any port are ignored.
  - On sdram_valid:
    - data<=sdram_data.
    - valid[grant]<=1 for exactly one cycle, only if req[grant] is still 1; otherwise the data is discarded with no pulse and served is left clear.
    - sdram_req<=0, busy<=0, served[grant]<=1 (only when pulsed), go to IDLE.
  - Total latency from sdram_valid to valid[i] is one cycle.
- Spacing: sdram_req is low for at least one cycle between consecutive transactions. IDLE always lasts at least one cycle after WAIT.
- Abandoned request: if req[grant] drops during WAIT, the SDRAM read still completes. It cannot be cancelled; the result is dropped.
- Stray sdram_valid while in IDLE: ignored, no output change.
- Simultaneous events:
  - A new req arriving in the same cycle as sdram_valid is considered in the following IDLE cycle.
  - req dropping in the same cycle as sdram_valid means no valid pulse.
- valid is one-hot or zero at all times. data holds its last value between pulses.
- Reset mid-transaction:
  - Outputs return to reset values immediately.
  - The SDRAM controller tolerates sdram_req dropping.
  - The first sdram_valid after reset lands in IDLE and is ignored.

Decomposition:
- Shared package rom_arb_pkg holds:
  - constants ROM_AW=23, ROM_DW=16, ARB_MAX_PORTS=8;
  - localparam state encoding IDLE=1'b0, WAIT=1'b1.
- One sub-module, rr_pick:
  - combinational round-robin selector;
  - inputs eligible[NUM_PORTS] and last;
  - outputs sel and any.
  - It is reusable by the sprite/tile fetch schedulers.

Test Plan:
- Single port: req[0]=1, addr0=0x001234, sdram_valid 5 cycles after sdram_req with data 0xBEEF -> sdram_addr=0x001234 one cycle after req; valid[0] pulses once, one cycle after sdram_valid; data=0xBEEF; busy low after.
- Round robin: all four req high from reset, each dropping req one cycle after its valid and re-raising two cycles later -> grant order 0,1,2,3,0,1; sdram_req low for at least 1 cycle between grants.
- Held req: port 1 holds req high for 20 cycles after its valid; port 2 idle -> no second SDRAM request for port 1 until req[1] drops and re-rises.
- Abandon: port 2 granted, req[2] dropped mid-WAIT, sdram_valid with 0x5555 -> no valid pulse on any port; next eligible port is granted in the following IDLE.
- Address hold: port 3 changes addr from 0x000010 to 0x000020 during WAIT -> sdram_addr stays 0x000010 until sdram_valid.
- Reset mid-WAIT: reset asserted two cycles after sdram_req, then sdram_valid arrives -> all outputs 0, no valid pulse; next grant goes to port 0 first.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the SDRAM ROM read-channel arbiter and its round-robin picker.
// Holds widths, the FSM state encoding and the wrap-distance helper.
package rom_arb_pkg;

    localparam int ROM_AW        = 23;
    localparam int ROM_DW        = 16;
    localparam int ARB_MAX_PORTS = 8;
    localparam int GRANT_W       = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // Distance of idx after last on a ring of n entries; last+1 is distance 0.
    function automatic int rr_dist(input int idx, input int last, input int n);
        return (idx - last + n - 32'sd1) % n;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible index after 'last', wrapping.
// Also used by the sprite/tile fetch schedulers.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [GRANT_W-1:0]   last,
    output logic [GRANT_W-1:0]   sel,
    output logic                 any
);

    int best_s;

    // Keep the eligible port with the smallest ring distance from last.
    always_comb begin
        sel    = 3'd0;
        any    = 1'b0;
        best_s = NUM_PORTS;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (eligible[i] && (rr_dist(i, int'(last), NUM_PORTS) < best_s)) begin
                best_s = rr_dist(i, int'(last), NUM_PORTS);
                sel    = GRANT_W'(i);
                any    = 1'b1;
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of the single SDRAM ROM read channel, one read in flight.
// Requesters hold req until a one-cycle valid; a port is re-served only after dropping req.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int AW        = ROM_AW,
    parameter int DW        = ROM_DW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [NUM_PORTS*AW-1:0] addr,
    output logic [NUM_PORTS-1:0]    valid,
    output logic [DW-1:0]           data,
    output logic [GRANT_W-1:0]      grant,
    output logic                    busy,
    output logic                    sdram_req,
    output logic [AW-1:0]           sdram_addr,
    input  logic [DW-1:0]           sdram_data,
    input  logic                    sdram_valid
);

    arb_state_t           state_r, state_nx_s;
    logic [NUM_PORTS-1:0] served_r, served_nx_s, eligible_s;
    logic [NUM_PORTS-1:0] valid_r, valid_nx_s;
    logic [GRANT_W-1:0]   last_r, grant_r, sel_s;
    logic                 any_s, start_s, done_s, hit_s, req_grant_s;
    logic [AW-1:0]        sel_addr_s, sdram_addr_r;
    logic [DW-1:0]        data_r;
    logic                 busy_r, sdram_req_r;

    assign eligible_s = req & ~served_r;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .eligible (eligible_s),
        .last     (last_r),
        .sel      (sel_s),
        .any      (any_s)
    );

    // Address of the winning port and live request level of the current owner.
    always_comb begin
        sel_addr_s  = {AW{1'b0}};
        req_grant_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_s == GRANT_W'(i)) begin
                sel_addr_s = addr[i*AW +: AW];
            end else begin
                sel_addr_s = sel_addr_s;
            end
            if (grant_r == GRANT_W'(i)) begin
                req_grant_s = req[i];
            end else begin
                req_grant_s = req_grant_s;
            end
        end
    end

    // Next state: grant from IDLE, complete in WAIT; a dropped owner gets no pulse.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        done_s     = 1'b0;
        hit_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    start_s    = 1'b1;
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (sdram_valid) begin
                    done_s     = 1'b1;
                    hit_s      = req_grant_s;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Per-port pulse and served bookkeeping; served clears whenever req is low.
    always_comb begin
        valid_nx_s  = {NUM_PORTS{1'b0}};
        served_nx_s = served_r;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (hit_s && (grant_r == GRANT_W'(i))) begin
                valid_nx_s[i]  = 1'b1;
                served_nx_s[i] = 1'b1;
            end else begin
                valid_nx_s[i]  = 1'b0;
            end
            if (!req[i]) begin
                served_nx_s[i] = 1'b0;
            end else begin
                served_nx_s[i] = served_nx_s[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered datapath; request and address stay frozen for the whole WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            served_r     <= {NUM_PORTS{1'b0}};
            valid_r      <= {NUM_PORTS{1'b0}};
            last_r       <= GRANT_W'(NUM_PORTS - 1);
            grant_r      <= 3'd0;
            sdram_addr_r <= {AW{1'b0}};
            sdram_req_r  <= 1'b0;
            busy_r       <= 1'b0;
            data_r       <= {DW{1'b0}};
        end else begin
            served_r <= served_nx_s;
            valid_r  <= valid_nx_s;
            if (start_s) begin
                grant_r      <= sel_s;
                last_r       <= sel_s;
                sdram_addr_r <= sel_addr_s;
                sdram_req_r  <= 1'b1;
                busy_r       <= 1'b1;
            end else if (done_s) begin
                sdram_req_r  <= 1'b0;
                busy_r       <= 1'b0;
            end
            if (hit_s) begin
                data_r <= sdram_data;
            end
        end
    end

    assign valid      = valid_r;
    assign data       = data_r;
    assign grant      = grant_r;
    assign busy       = busy_r;
    assign sdram_req  = sdram_req_r;
    assign sdram_addr = sdram_addr_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: vector table, directed corner sequences, and
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    valid;
    logic [DW-1:0]   data;
    logic [2:0]      grant;
    logic            busy, sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic [DW-1:0]   sdram_data;
    logic            sdram_valid;

    always #5 clk = ~clk;

    rom_arbiter #(.NUM_PORTS(N), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .addr        (addr),
        .valid       (valid),
        .data        (data),
        .grant       (grant),
        .busy        (busy),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_data  (sdram_data),
        .sdram_valid (sdram_valid)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the channel, which ports were served, last winner.
    bit [N-1:0]  served_m;
    int          last_m, own_m;
    bit          infl_m;
    logic [N-1:0]  mvalid;
    logic [DW-1:0] mdata;
    logic [2:0]    mgrant;
    logic [AW-1:0] maddr;

    // SDRAM responder controls.
    bit auto_sdram = 1'b0;
    bit stray_en   = 1'b0;
    int lat        = 2;
    int lat_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] nv;
        nv = '0;
        if (reset) begin
            served_m = '0; last_m = N - 1; infl_m = 1'b0; own_m = 0;
            mvalid = '0; mdata = '0; mgrant = '0; maddr = '0;
        end else begin
            if (!infl_m) begin
                for (int k = 1; k <= N; k++) begin
                    int p;
                    p = (last_m + k) % N;
                    if (req[p] && !served_m[p]) begin
                        infl_m = 1'b1; own_m = p; last_m = p;
                        mgrant = 3'(p);
                        maddr  = addr[p*AW +: AW];
                        break;
                    end
                end
            end else if (sdram_valid) begin
                infl_m = 1'b0;
                if (req[own_m]) begin
                    nv[own_m] = 1'b1;
                    mdata = sdram_data;
                    served_m[own_m] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) if (!req[i]) served_m[i] = 1'b0;
            mvalid = nv;
        end
    endtask

    task automatic cycle();
        if (auto_sdram) begin
            if (sdram_req && lat_cnt >= lat) begin
                sdram_valid = 1'b1; sdram_data = 16'($urandom);
            end else if (stray_en && !sdram_req && $urandom_range(0, 7) == 0) begin
                sdram_valid = 1'b1; sdram_data = 16'($urandom);
            end else begin
                sdram_valid = 1'b0;
            end
        end
        @(posedge clk);
        model_step();
        #1;
        chk("m_valid", valid, mvalid);
        chk("m_data", data, mdata);
        chk("m_busy", busy, infl_m);
        chk("m_sdram_req", sdram_req, infl_m);
        if (infl_m || reset) begin
            chk("m_grant", grant, mgrant);
            chk("m_sdram_addr", sdram_addr, maddr);
        end
        if (sdram_req) lat_cnt++; else lat_cnt = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; sdram_valid = 1'b0; req = '0;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic rst; logic [3:0] req; logic [22:0] a0; logic sdv; logic [15:0] sdd;
        logic [3:0] ev; logic [15:0] ed; logic [2:0] eg; logic eb; logic er; logic [22:0] ea;
    } vec_t;

    vec_t tbl[10];
    int   rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int n, rises, guard;
        int down[N];
        bit prev_sreq, got;

        reset = 1'b1; req = '0; addr = '0; sdram_valid = 1'b0; sdram_data = '0;

        // Single-port table: sdram_valid five cycles after sdram_req, held req, drop, re-raise.
        tbl[0] = '{1'b1, 4'h0, 23'h0, 1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 1'b0, 1'b0, 23'h0};
        for (int r = 1; r <= 5; r++)
            tbl[r] = '{1'b0, 4'h1, 23'h001234, 1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 1'b1, 1'b1, 23'h001234};
        tbl[6] = '{1'b0, 4'h1, 23'h001234, 1'b1, 16'hBEEF, 4'h1, 16'hBEEF, 3'd0, 1'b0, 1'b0, 23'h001234};
        tbl[7] = '{1'b0, 4'h1, 23'h001234, 1'b0, 16'h0, 4'h0, 16'hBEEF, 3'd0, 1'b0, 1'b0, 23'h001234};
        tbl[8] = '{1'b0, 4'h0, 23'h001234, 1'b0, 16'h0, 4'h0, 16'hBEEF, 3'd0, 1'b0, 1'b0, 23'h001234};
        tbl[9] = '{1'b0, 4'h1, 23'h001234, 1'b0, 16'h0, 4'h0, 16'hBEEF, 3'd0, 1'b1, 1'b1, 23'h001234};
        for (int r = 0; r < 10; r++) begin
            reset = tbl[r].rst; req = tbl[r].req; addr = '0; addr[AW-1:0] = tbl[r].a0;
            sdram_valid = tbl[r].sdv; sdram_data = tbl[r].sdd;
            cycle();
            chk("tbl_valid", valid, tbl[r].ev);
            chk("tbl_data", data, tbl[r].ed);
            chk("tbl_grant", grant, tbl[r].eg);
            chk("tbl_busy", busy, tbl[r].eb);
            chk("tbl_sdram_req", sdram_req, tbl[r].er);
            chk("tbl_sdram_addr", sdram_addr, tbl[r].ea);
        end

        // Round robin with drop-and-reraise requesters.
        do_reset();
        for (int p = 0; p < N; p++) begin addr[p*AW +: AW] = 23'(32'h40 + p); down[p] = 0; end
        auto_sdram = 1'b1; lat = 2; n = 0; guard = 0;
        while (n < 6 && guard < 200) begin
            for (int p = 0; p < N; p++) begin
                if (down[p] > 0) begin req[p] = 1'b0; down[p]--; end else req[p] = 1'b1;
            end
            prev_sreq = sdram_req;
            cycle();
            if (sdram_req && !prev_sreq) begin chk("rr_order", grant, rr_exp[n]); n++; end
            if (valid != '0) chk("rr_gap", sdram_req, 1'b0);
            for (int p = 0; p < N; p++) if (valid[p]) down[p] = 2;
            guard++;
        end
        chk("rr_count", n, 6);

        // Held request is not re-served until it drops.
        auto_sdram = 1'b0; do_reset(); auto_sdram = 1'b1; lat = 1;
        req = 4'b0010; got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin cycle(); if (valid[1]) got = 1'b1; end
        chk("held_first", got, 1'b1);
        rises = 0;
        for (int c = 0; c < 20; c++) begin
            prev_sreq = sdram_req; cycle();
            if (sdram_req && !prev_sreq) rises++;
        end
        chk("held_no_rereq", rises, 0);
        req = 4'b0000; cycle();
        req = 4'b0010; cycle();
        chk("held_rereq", sdram_req, 1'b1);
        chk("held_rereq_grant", grant, 3'd1);

        // Abandon: port 2 drops mid-WAIT; port 3 gets the next IDLE.
        auto_sdram = 1'b0; do_reset();
        addr[2*AW +: AW] = 23'h000222; addr[3*AW +: AW] = 23'h000333;
        req = 4'b0100; cycle();
        chk("ab_grant", grant, 3'd2);
        req = 4'b1000; cycle(); cycle();
        chk("ab_busy", busy, 1'b1);
        sdram_valid = 1'b1; sdram_data = 16'h5555; cycle();
        chk("ab_no_valid", valid, 4'b0000);
        chk("ab_sreq_low", sdram_req, 1'b0);
        sdram_valid = 1'b0; cycle();
        chk("ab_next_grant", grant, 3'd3);
        chk("ab_next_sreq", sdram_req, 1'b1);
        chk("ab_next_addr", sdram_addr, 23'h000333);
        sdram_valid = 1'b1; sdram_data = 16'h1357; cycle();
        chk("ab_p3_valid", valid, 4'b1000);
        chk("ab_p3_data", data, 16'h1357);
        sdram_valid = 1'b0;

        // Address hold during WAIT.
        do_reset();
        addr[3*AW +: AW] = 23'h000010; req = 4'b1000; cycle();
        chk("ah_addr0", sdram_addr, 23'h000010);
        addr[3*AW +: AW] = 23'h000020;
        for (int c = 0; c < 3; c++) begin cycle(); chk("ah_addr_hold", sdram_addr, 23'h000010); end
        sdram_valid = 1'b1; sdram_data = 16'hA5A5; cycle();
        chk("ah_valid", valid, 4'b1000);
        chk("ah_data", data, 16'hA5A5);
        sdram_valid = 1'b0; req = 4'b0000; cycle();

        // Reset two cycles after sdram_req, then a late sdram_valid lands in IDLE.
        do_reset();
        for (int p = 0; p < N; p++) addr[p*AW +: AW] = 23'(32'h100 + p);
        req = 4'b1111; cycle();
        chk("rm_grant0", grant, 3'd0);
        sdram_valid = 1'b1; sdram_data = 16'h7777; cycle();
        sdram_valid = 1'b0; cycle();
        chk("rm_grant1", grant, 3'd1);
        cycle();
        reset = 1'b1; cycle();
        chk("rm_sreq", sdram_req, 1'b0);
        chk("rm_busy", busy, 1'b0);
        chk("rm_grant", grant, 3'd0);
        chk("rm_addr", sdram_addr, 23'h0);
        chk("rm_data", data, 16'h0);
        reset = 1'b0; req = 4'b0000; sdram_valid = 1'b1; sdram_data = 16'h9999; cycle();
        chk("rm_stray_valid", valid, 4'b0000);
        chk("rm_stray_sreq", sdram_req, 1'b0);
        chk("rm_stray_data", data, 16'h0);
        sdram_valid = 1'b0; req = 4'b1111; cycle();
        chk("rm_first_grant", grant, 3'd0);
        chk("rm_first_sreq", sdram_req, 1'b1);
        chk("rm_first_addr", sdram_addr, 23'h000100);

        // Randomized traffic against the model.
        do_reset();
        auto_sdram = 1'b1; stray_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!sdram_req) lat = $urandom_range(0, 4);
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 5) == 0) req[p] = ~req[p];
                if ($urandom_range(0, 3) == 0) addr[p*AW +: AW] = 23'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle();
            chk("rnd_onehot", $countones(valid) <= 1, 1'b1);
        end
        reset = 1'b0; auto_sdram = 1'b0; stray_en = 1'b0; sdram_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
